vga_timing: RTL and testbench

Source end of the VGA pipeline: generates the horizontal/vertical counters, sync and blanking strobes that every draw stage consumes. Stage ports mirror the count/sync/blank inputs of the draw stages, so outputs connect directly. Adds a frame pulse and frame counter so screen sequencers can count in whole frames. Default mode is 800x600@60 Hz on a 40 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_timing_mod_counter.sv | 54 +++++
 rtl/vga_timing.sv | 130 +++++++++++++
 tb/tb_vga_timing.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared screen-geometry definitions for the VGA pipeline. Holds the default
// 800x600@60 Hz mode (40 MHz pixel clock), the derived line/frame totals and
// the count width that every draw stage uses for hcount/vcount.
// Ports: none (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_VISIBLE = 800;
   localparam int DEF_H_FP      = 40;
   localparam int DEF_H_SYNC    = 128;
   localparam int DEF_H_BP      = 88;
   localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_VISIBLE = 600;
   localparam int DEF_V_FP      = 1;
   localparam int DEF_V_SYNC    = 4;
   localparam int DEF_V_BP      = 23;
   localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int DEF_FCNT_W    = 16;

   // True when lo <= v < hi_excl (half-open window used for sync pulses).
   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi_excl);
      return (v >= lo) && (v < hi_excl);
   endfunction

endpackage

// File: rtl/vga_timing_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-MOD up-counter with enable. Counts 0..MOD-1, wrapping to 0.
// Ports:
//   pclk      in   clock, rising edge
//   reset     in   synchronous active-high reset (count -> 0)
//   inc       in   advance the count this cycle
//   count     out  registered count value
//   count_nxt out  value count takes on the next edge (lets the parent register
//                  decoded strobes so they line up with count)
//   wrap      out  inc is set and count is at MOD-1 (the next edge wraps)
// -----------------------------------------------------------------------------
module mod_counter #(
   parameter int MOD = 2,
   parameter int W   = 1
) (
   input  logic         pclk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next-count and wrap decode.
   always_comb begin
      wrap = inc && (count_q == LAST);
      if (!inc) begin
         count_d = count_q;
      end else if (wrap) begin
         count_d = '0;
      end else begin
         count_d = count_q + W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge pclk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign count_nxt = count_d;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Source end of the VGA pipeline: horizontal/vertical counters, sync and
// blanking strobes, plus a frame-start pulse and completed-frame counter.
// Every strobe is registered from the next-count values, so in any cycle the
// strobes describe exactly the hcount_out/vcount_out presented alongside them.
// Ports:
//   pclk        in   pixel clock, rising edge
//   reset       in   synchronous active-high reset
//   hcount_out  out  pixel index in line, 0..H_TOTAL-1
//   hsync_out   out  horizontal sync, active-high
//   hblnk_out   out  horizontal blanking
//   vcount_out  out  line index in frame, 0..V_TOTAL-1
//   vsync_out   out  vertical sync, active-high (whole lines)
//   vblnk_out   out  vertical blanking
//   frame_tick  out  one-cycle pulse coincident with counts (0,0) of a new frame
//   frame_cnt   out  completed-frame count, wraps modulo 2^FCNT_W
// -----------------------------------------------------------------------------
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter int FCNT_W    = DEF_FCNT_W
) (
   input  logic              pclk,
   input  logic              reset,
   output logic [10:0]       hcount_out,
   output logic              hsync_out,
   output logic              hblnk_out,
   output logic [10:0]       vcount_out,
   output logic              vsync_out,
   output logic              vblnk_out,
   output logic              frame_tick,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] HB_START = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VB_START = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

   logic [CNT_W-1:0]  hcount_s;
   logic [CNT_W-1:0]  h_nxt_s;
   logic              h_wrap_s;
   logic [CNT_W-1:0]  vcount_s;
   logic [CNT_W-1:0]  v_nxt_s;
   logic              v_wrap_s;

   logic              hsync_q, hsync_d;
   logic              hblnk_q, hblnk_d;
   logic              vsync_q, vsync_d;
   logic              vblnk_q, vblnk_d;
   logic              frame_tick_q, frame_tick_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

   mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_hcnt (
      .pclk      (pclk),
      .reset     (reset),
      .inc       (1'b1),
      .count     (hcount_s),
      .count_nxt (h_nxt_s),
      .wrap      (h_wrap_s)
   );

   // vcount only moves on the last pixel of a line, so its wrap marks the
   // final pixel of the frame.
   mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_vcnt (
      .pclk      (pclk),
      .reset     (reset),
      .inc       (h_wrap_s),
      .count     (vcount_s),
      .count_nxt (v_nxt_s),
      .wrap      (v_wrap_s)
   );

   // Strobe decode from next counts so registered strobes align with counts.
   always_comb begin
      hblnk_d      = (h_nxt_s >= HB_START);
      hsync_d      = in_window(h_nxt_s, HS_START, HS_END);
      vblnk_d      = (v_nxt_s >= VB_START);
      vsync_d      = in_window(v_nxt_s, VS_START, VS_END);
      frame_tick_d = v_wrap_s;
      if (v_wrap_s) begin
         frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Strobe and frame-counter registers; reset is deliberately not a frame start.
   always_ff @(posedge pclk) begin
      if (reset) begin
         hsync_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         vsync_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         frame_tick_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         hsync_q      <= hsync_d;
         hblnk_q      <= hblnk_d;
         vsync_q      <= vsync_d;
         vblnk_q      <= vblnk_d;
         frame_tick_q <= frame_tick_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign hcount_out = hcount_s;
   assign vcount_out = vcount_s;
   assign hsync_out  = hsync_q;
   assign hblnk_out  = hblnk_q;
   assign vsync_out  = vsync_q;
   assign vblnk_out  = vblnk_q;
   assign frame_tick = frame_tick_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Two instances share clock and reset: dut_d in the default 800x600 mode for
// reset and line-level checks, dut_s in a reduced mode (16 pixels x 10 lines,
// FCNT_W = 2) so whole frames and frame-counter wrap fit in a short run.
// Reduced mode: hblnk h>=8, hsync h 10..12, vblnk v>=6, vsync v 7..8,
// frame = 16*10 = 160 cycles.
// -----------------------------------------------------------------------------
module tb_vga_timing;

   logic        pclk = 1'b0;
   logic        reset;

   logic [10:0] d_hcount, d_vcount;
   logic        d_hsync, d_hblnk, d_vsync, d_vblnk, d_tick;
   logic [15:0] d_fcnt;

   logic [10:0] s_hcount, s_vcount;
   logic        s_hsync, s_hblnk, s_vsync, s_vblnk, s_tick;
   logic [1:0]  s_fcnt;

   int checks = 0;
   int passes = 0;

   always #5 pclk = ~pclk;

   vga_timing dut_d (
      .pclk(pclk), .reset(reset),
      .hcount_out(d_hcount), .hsync_out(d_hsync), .hblnk_out(d_hblnk),
      .vcount_out(d_vcount), .vsync_out(d_vsync), .vblnk_out(d_vblnk),
      .frame_tick(d_tick), .frame_cnt(d_fcnt)
   );

   vga_timing #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .FCNT_W(2)
   ) dut_s (
      .pclk(pclk), .reset(reset),
      .hcount_out(s_hcount), .hsync_out(s_hsync), .hblnk_out(s_hblnk),
      .vcount_out(s_vcount), .vsync_out(s_vsync), .vblnk_out(s_vblnk),
      .frame_tick(s_tick), .frame_cnt(s_fcnt)
   );

   task automatic step();
      @(posedge pclk);
      @(negedge pclk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_tick, d_fcnt} !== '0)
            $display("FAIL reset_d cyc%0d: h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b tick=%b cnt=%0d, need all 0",
                     i, d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_tick, d_fcnt);
         else passes++;
      end
      checks++;
      if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_tick, s_fcnt} !== '0)
         $display("FAIL reset_s: h=%0d v=%0d tick=%b cnt=%0d, need all 0", s_hcount, s_vcount, s_tick, s_fcnt);
      else passes++;
      reset = 1'b0;
      step();
      checks++;
      if (d_hcount !== 11'd1) $display("FAIL release_hcount: got %0d need 1", d_hcount);
      else passes++;
      checks++;
      if (d_vcount !== 11'd0) $display("FAIL release_vcount: got %0d need 0", d_vcount);
      else passes++;
      checks++;
      if (d_tick !== 1'b0 || s_tick !== 1'b0) $display("FAIL release_tick: got %b/%b need 0/0", d_tick, s_tick);
      else passes++;
   endtask

   task automatic test_line();
      int hb_rise = -1, hs_first = -1, hs_last = -1, hs_len = 0, align_err = 0, v_err = 0;
      // Sample k of the loop shows hcount k+2; the last one shows the wrap.
      for (int i = 0; i < 1055; i++) begin
         step();
         if (d_hblnk === 1'b1 && hb_rise < 0) hb_rise = int'(d_hcount);
         if (d_hsync === 1'b1) begin
            if (hs_first < 0) hs_first = int'(d_hcount);
            hs_last = int'(d_hcount);
            hs_len++;
         end
         if (d_hblnk !== (d_hcount >= 11'd800) ||
             d_hsync !== (d_hcount >= 11'd840 && d_hcount <= 11'd967)) align_err++;
         if (i < 1054 && d_vcount !== 11'd0) v_err++;
      end
      checks++;
      if (hb_rise !== 800) $display("FAIL hblnk_rise: got %0d need 800", hb_rise);
      else passes++;
      checks++;
      if (hs_first !== 840) $display("FAIL hsync_first: got %0d need 840", hs_first);
      else passes++;
      checks++;
      if (hs_last !== 967) $display("FAIL hsync_last: got %0d need 967", hs_last);
      else passes++;
      checks++;
      if (hs_len !== 128) $display("FAIL hsync_len: got %0d need 128", hs_len);
      else passes++;
      checks++;
      if (align_err !== 0) $display("FAIL h_strobe_align: got %0d bad cycles need 0", align_err);
      else passes++;
      checks++;
      if (v_err !== 0) $display("FAIL v_hold_line0: got %0d bad cycles need 0", v_err);
      else passes++;
      checks++;
      if (d_hcount !== 11'd0 || d_vcount !== 11'd1)
         $display("FAIL line_wrap: got (%0d,%0d) need (0,1)", d_hcount, d_vcount);
      else passes++;
      checks++;
      if (d_hblnk !== 1'b0 || d_tick !== 1'b0) $display("FAIL line_wrap_flags: hb=%b tick=%b need 0,0", d_hblnk, d_tick);
      else passes++;
   endtask

   task automatic test_frame();
      int n = 0, found = 0, align_err = 0;
      int vb_first = -1, vb_last = -1, vb_len = 0;
      int vs_first = -1, vs_last = -1, vs_len = 0, vs_rise_h = -1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      checks++;
      if (s_hcount !== 11'd1 || s_fcnt !== 2'd0) $display("FAIL frame_start: h=%0d cnt=%0d need 1,0", s_hcount, s_fcnt);
      else passes++;
      while (found == 0 && n < 200) begin
         step();
         n++;
         if (s_tick === 1'b1) found = 1;
         if (s_vblnk === 1'b1) begin
            if (vb_first < 0) vb_first = int'(s_vcount);
            vb_last = int'(s_vcount);
            vb_len++;
         end
         if (s_vsync === 1'b1) begin
            if (vs_first < 0) begin
               vs_first  = int'(s_vcount);
               vs_rise_h = int'(s_hcount);
            end
            vs_last = int'(s_vcount);
            vs_len++;
         end
         if (s_vblnk !== (s_vcount >= 11'd6) || s_vsync !== (s_vcount >= 11'd7 && s_vcount <= 11'd8) ||
             s_hblnk !== (s_hcount >= 11'd8) || s_hsync !== (s_hcount >= 11'd10 && s_hcount <= 11'd12))
            align_err++;
      end
      checks++;
      if (n !== 159) $display("FAIL frame_len: tick after %0d cycles need 159", n);
      else passes++;
      checks++;
      if (vb_first !== 6 || vb_last !== 9 || vb_len !== 64)
         $display("FAIL vblnk_span: got v%0d..v%0d len %0d need 6..9 len 64", vb_first, vb_last, vb_len);
      else passes++;
      checks++;
      if (vs_first !== 7 || vs_last !== 8 || vs_len !== 32)
         $display("FAIL vsync_span: got v%0d..v%0d len %0d need 7..8 len 32", vs_first, vs_last, vs_len);
      else passes++;
      checks++;
      if (vs_rise_h !== 0) $display("FAIL vsync_rise_h: got %0d need 0", vs_rise_h);
      else passes++;
      checks++;
      if (align_err !== 0) $display("FAIL strobe_align: got %0d bad cycles need 0", align_err);
      else passes++;
      checks++;
      if (s_hcount !== 11'd0 || s_vcount !== 11'd0 || s_fcnt !== 2'd1)
         $display("FAIL frame_wrap: got (%0d,%0d) cnt %0d need (0,0) cnt 1", s_hcount, s_vcount, s_fcnt);
      else passes++;
      step();
      checks++;
      if (s_tick !== 1'b0 || s_hcount !== 11'd1) $display("FAIL tick_width: tick=%b h=%0d need 0,1", s_tick, s_hcount);
      else passes++;
   endtask

   task automatic test_multi_frame();
      int sp[3];
      int fc[3];
      int ticks = 0, since = 1, dbl = 0, n = 0;
      logic prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sp[i] = -1;
         fc[i] = -1;
      end
      while (ticks < 3 && n < 600) begin
         step();
         n++;
         since++;
         if (s_tick === 1'b1 && prev === 1'b1) dbl++;
         prev = s_tick;
         if (s_tick === 1'b1) begin
            sp[ticks] = since;
            fc[ticks] = int'(s_fcnt);
            ticks++;
            since = 0;
         end
      end
      checks++;
      if (ticks !== 3) $display("FAIL tick_count: got %0d need 3", ticks);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (sp[i] !== 160) $display("FAIL tick_spacing%0d: got %0d need 160", i, sp[i]);
         else passes++;
      end
      checks++;
      if (fc[0] !== 2 || fc[1] !== 3 || fc[2] !== 0)
         $display("FAIL fcnt_wrap: got %0d,%0d,%0d need 2,3,0", fc[0], fc[1], fc[2]);
      else passes++;
      checks++;
      if (dbl !== 0) $display("FAIL double_tick: got %0d need 0", dbl);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int n = 0, found = 0;
      while (!(s_hcount === 11'd4 && s_vcount === 11'd3) && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (s_hcount !== 11'd4 || s_vcount !== 11'd3) $display("FAIL reach_mid: got (%0d,%0d) need (4,3)", s_hcount, s_vcount);
      else passes++;
      reset = 1'b1;
      step();
      checks++;
      if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_tick, s_fcnt} !== '0)
         $display("FAIL mid_reset_s: h=%0d v=%0d tick=%b cnt=%0d need all 0", s_hcount, s_vcount, s_tick, s_fcnt);
      else passes++;
      checks++;
      if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_tick, d_fcnt} !== '0)
         $display("FAIL mid_reset_d: h=%0d v=%0d need all 0", d_hcount, d_vcount);
      else passes++;
      reset = 1'b0;
      step();
      checks++;
      if (s_hcount !== 11'd1 || s_vcount !== 11'd0 || s_tick !== 1'b0 || s_fcnt !== 2'd0)
         $display("FAIL restart1: got (%0d,%0d) tick %b cnt %0d need (1,0) 0 0", s_hcount, s_vcount, s_tick, s_fcnt);
      else passes++;
      step();
      checks++;
      if (s_hcount !== 11'd2 || s_vcount !== 11'd0) $display("FAIL restart2: got (%0d,%0d) need (2,0)", s_hcount, s_vcount);
      else passes++;
      n = 0;
      while (found == 0 && n < 200) begin
         step();
         n++;
         if (s_tick === 1'b1) found = 1;
      end
      checks++;
      if (n !== 158 || s_fcnt !== 2'd1) $display("FAIL restart_frame: tick after %0d cnt %0d need 158 cnt 1", n, s_fcnt);
      else passes++;
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_line();
      test_frame();
      test_multi_frame();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
